risc_host_loader: RTL and testbench

Host-side initiator for the CPU core's external test/load port. It streams a program into instruction memory and an initial image into data memory, then releases the core and runs it until `done` or a watchdog timeout. Afterwards it captures `outR` and streams a data-memory dump out on a valid/ready channel. It sits between the testbench/host link and the CPU top level, driving `ext_IR_we`, `ext_DM_we`, `ext_addr`, `ext_data`, `test_normal` and the core reset.

---
 rtl/risc_host_pkg.sv | 27 ++
 rtl/risc_host_watchdog.sv | 27 ++
 rtl/risc_host_loader.sv | 247 ++++++++++++++++++++++++
 tb/tb_risc_host_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/risc_host_pkg.sv
// Shared types and address widths for the host-side load/run/dump initiator.
package risc_host_pkg;

   localparam int IR_DEPTH_DEF = 32;
   localparam int DM_DEPTH_DEF = 256;
   localparam int IR_AW        = $clog2(IR_DEPTH_DEF);
   localparam int DM_AW        = $clog2(DM_DEPTH_DEF);

   typedef enum logic [3:0] {
      IDLE,
      LOAD_IR,
      LOAD_DM,
      RUN_RST,
      RUN,
      DUMP_ADDR,
      DUMP_WAIT,
      DUMP_OUT,
      FINISH
   } host_state_e;

   typedef enum logic [1:0] {
      ST_NONE    = 2'b00,
      ST_DONE    = 2'b01,
      ST_TIMEOUT = 2'b10
   } host_status_e;

endpackage

// File: rtl/risc_host_watchdog.sv
// Saturating run-cycle counter; limit_hit flags that the budget is spent.
module risc_host_watchdog #(
   parameter int WIDTH      = 16,
   parameter int MAX_CYCLES = 65535
) (
   input  logic             clk,
   input  logic             cpu_reset_n,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] count,
   output logic             limit_hit
);

   localparam logic [WIDTH-1:0] LIMIT = WIDTH'(MAX_CYCLES);

   always_ff @(posedge clk or negedge cpu_reset_n) begin
      if (!cpu_reset_n)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (en && (count != LIMIT))
         count <= count + WIDTH'(1);
   end

   assign limit_hit = (count == LIMIT);

endmodule

// File: rtl/risc_host_loader.sv
// Host initiator: loads IR/DM through the core test port, runs the core with a
// watchdog, captures outR and streams a DM dump out on a valid/ready channel.
module risc_host_loader
   import risc_host_pkg::*;
#(
   parameter int WIDTH      = 16,
   parameter int IR_DEPTH   = IR_DEPTH_DEF,
   parameter int DM_DEPTH   = DM_DEPTH_DEF,
   parameter int RD_LAT     = 1,
   parameter int MAX_CYCLES = 65535,
   parameter int RST_HOLD   = 2
) (
   input  logic             clk,
   input  logic             cpu_reset_n,
   input  logic             start,
   input  logic [IR_AW:0]   ir_len,
   input  logic [DM_AW:0]   dm_len,
   input  logic [DM_AW:0]   dump_len,
   input  logic             s_valid,
   input  logic [WIDTH-1:0] s_data,
   output logic             s_ready,
   output logic             m_valid,
   output logic [WIDTH-1:0] m_data,
   input  logic             m_ready,
   output logic             ext_IR_we,
   output logic             ext_DM_we,
   output logic [DM_AW-1:0] ext_addr,
   output logic [WIDTH-1:0] ext_data,
   output logic             test_normal,
   output logic             core_reset_n,
   input  logic [WIDTH-1:0] mem_out,
   input  logic [WIDTH-1:0] outR,
   input  logic             done,
   output logic             busy,
   output logic [1:0]       status,
   output logic [WIDTH-1:0] result_outr,
   output logic [15:0]      cycle_count
);

   localparam int             IAW       = $clog2(IR_DEPTH);
   localparam int             DAW       = $clog2(DM_DEPTH);
   localparam int             LW        = DM_AW + 1;
   localparam logic [7:0]     RST_HOLD_W = 8'(RST_HOLD);
   localparam logic [7:0]     RD_LAT_W   = 8'(RD_LAT);

   host_state_e      state, state_nxt;
   logic [LW-1:0]    idx, idx_nxt, idx_inc;
   logic [7:0]       wcnt, wcnt_nxt;
   logic [IR_AW:0]   ir_len_q, ir_len_nxt;
   logic [DM_AW:0]   dm_len_q, dm_len_nxt, dump_len_q, dump_len_nxt;
   logic             s_ready_nxt, m_valid_nxt, busy_nxt;
   logic             ext_IR_we_nxt, ext_DM_we_nxt, test_normal_nxt, core_reset_n_nxt;
   logic [WIDTH-1:0] m_data_nxt, ext_data_nxt, result_nxt;
   logic [DM_AW-1:0] ext_addr_nxt;
   logic [1:0]       status_nxt;
   logic             wd_clr, wd_en, limit_hit, xfer;

   risc_host_watchdog #(.WIDTH(16), .MAX_CYCLES(MAX_CYCLES)) u_wd (
      .clk         (clk),
      .cpu_reset_n (cpu_reset_n),
      .clr         (wd_clr),
      .en          (wd_en),
      .count       (cycle_count),
      .limit_hit   (limit_hit)
   );

   always_ff @(posedge clk or negedge cpu_reset_n) begin
      if (!cpu_reset_n) begin
         state        <= IDLE;
         idx          <= '0;
         wcnt         <= '0;
         ir_len_q     <= '0;
         dm_len_q     <= '0;
         dump_len_q   <= '0;
         s_ready      <= 1'b0;
         m_valid      <= 1'b0;
         m_data       <= '0;
         ext_IR_we    <= 1'b0;
         ext_DM_we    <= 1'b0;
         ext_addr     <= '0;
         ext_data     <= '0;
         test_normal  <= 1'b1;
         core_reset_n <= 1'b0;
         busy         <= 1'b0;
         status       <= ST_NONE;
         result_outr  <= '0;
      end else begin
         state        <= state_nxt;
         idx          <= idx_nxt;
         wcnt         <= wcnt_nxt;
         ir_len_q     <= ir_len_nxt;
         dm_len_q     <= dm_len_nxt;
         dump_len_q   <= dump_len_nxt;
         s_ready      <= s_ready_nxt;
         m_valid      <= m_valid_nxt;
         m_data       <= m_data_nxt;
         ext_IR_we    <= ext_IR_we_nxt;
         ext_DM_we    <= ext_DM_we_nxt;
         ext_addr     <= ext_addr_nxt;
         ext_data     <= ext_data_nxt;
         test_normal  <= test_normal_nxt;
         core_reset_n <= core_reset_n_nxt;
         busy         <= busy_nxt;
         status       <= status_nxt;
         result_outr  <= result_nxt;
      end
   end

   assign idx_inc = idx + LW'(1);
   assign xfer    = s_valid && s_ready;

   always_comb begin
      state_nxt        = state;
      idx_nxt          = idx;
      wcnt_nxt         = '0;
      ir_len_nxt       = ir_len_q;
      dm_len_nxt       = dm_len_q;
      dump_len_nxt     = dump_len_q;
      s_ready_nxt      = s_ready;
      m_valid_nxt      = m_valid;
      m_data_nxt       = m_data;
      ext_IR_we_nxt    = 1'b0;
      ext_DM_we_nxt    = 1'b0;
      ext_addr_nxt     = ext_addr;
      ext_data_nxt     = ext_data;
      test_normal_nxt  = test_normal;
      core_reset_n_nxt = core_reset_n;
      busy_nxt         = busy;
      status_nxt       = status;
      result_nxt       = result_outr;
      wd_clr           = 1'b0;
      wd_en            = 1'b0;

      case (state)
         IDLE: begin
            if (start) begin
               ir_len_nxt   = ir_len;
               dm_len_nxt   = dm_len;
               dump_len_nxt = dump_len;
               busy_nxt     = 1'b1;
               status_nxt   = ST_NONE;
               wd_clr       = 1'b1;
               idx_nxt      = '0;
               if (ir_len != '0) begin
                  state_nxt   = LOAD_IR;
                  s_ready_nxt = 1'b1;
               end else if (dm_len != '0) begin
                  state_nxt   = LOAD_DM;
                  s_ready_nxt = 1'b1;
               end else begin
                  state_nxt   = RUN_RST;
               end
            end
         end

         LOAD_IR: begin
            if (xfer) begin
               ext_IR_we_nxt = 1'b1;
               ext_addr_nxt  = DM_AW'(idx[IAW-1:0]);
               ext_data_nxt  = s_data;
               idx_nxt       = idx_inc;
               if (idx_inc == LW'(ir_len_q)) begin
                  idx_nxt = '0;
                  if (dm_len_q != '0) begin
                     state_nxt = LOAD_DM;
                  end else begin
                     s_ready_nxt = 1'b0;
                     state_nxt   = RUN_RST;
                  end
               end
            end
         end

         LOAD_DM: begin
            if (xfer) begin
               ext_DM_we_nxt = 1'b1;
               ext_addr_nxt  = DM_AW'(idx[DAW-1:0]);
               ext_data_nxt  = s_data;
               idx_nxt       = idx_inc;
               if (idx_inc == dm_len_q) begin
                  idx_nxt     = '0;
                  s_ready_nxt = 1'b0;
                  state_nxt   = RUN_RST;
               end
            end
         end

         // First cycle still lets the final load write land with test_normal=1.
         RUN_RST: begin
            test_normal_nxt  = 1'b0;
            core_reset_n_nxt = 1'b0;
            if (wcnt == RST_HOLD_W) begin
               core_reset_n_nxt = 1'b1;
               state_nxt        = RUN;
            end else begin
               wcnt_nxt = wcnt + 8'd1;
            end
         end

         RUN: begin
            wd_en = !done && !limit_hit;
            if (done || limit_hit) begin
               result_nxt       = outR;
               status_nxt       = done ? ST_DONE : ST_TIMEOUT;
               core_reset_n_nxt = 1'b0;
               test_normal_nxt  = 1'b1;
               idx_nxt          = '0;
               ext_addr_nxt     = '0;
               state_nxt        = (dump_len_q == '0) ? FINISH : DUMP_ADDR;
            end
         end

         // ext_addr is already valid on entry; count off RD_LAT cycles then sample.
         DUMP_ADDR, DUMP_WAIT: begin
            if (wcnt == RD_LAT_W) begin
               m_data_nxt  = mem_out;
               m_valid_nxt = 1'b1;
               state_nxt   = DUMP_OUT;
            end else begin
               wcnt_nxt  = wcnt + 8'd1;
               state_nxt = DUMP_WAIT;
            end
         end

         DUMP_OUT: begin
            if (m_ready) begin
               m_valid_nxt = 1'b0;
               idx_nxt     = idx_inc;
               if (idx_inc == dump_len_q) begin
                  state_nxt = FINISH;
               end else begin
                  ext_addr_nxt = DM_AW'(idx_inc[DAW-1:0]);
                  state_nxt    = DUMP_ADDR;
               end
            end
         end

         FINISH: begin
            busy_nxt  = 1'b0;
            state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_risc_host_loader.sv
// Directed bench: load, run/done, timeout with dump backpressure, mid-job abort.
module tb_risc_host_loader;

   logic        clk = 1'b0;
   logic        cpu_reset_n = 1'b0;
   logic        start = 1'b0;
   logic [5:0]  ir_len = '0;
   logic [8:0]  dm_len = '0;
   logic [8:0]  dump_len = '0;
   logic        s_valid = 1'b0;
   logic [15:0] s_data = '0;
   logic        s_ready;
   logic        m_valid;
   logic [15:0] m_data;
   logic        m_ready = 1'b0;
   logic        ext_IR_we, ext_DM_we;
   logic [7:0]  ext_addr;
   logic [15:0] ext_data;
   logic        test_normal, core_reset_n;
   logic [15:0] mem_out = '0;
   logic [15:0] outR = '0;
   logic        done = 1'b0;
   logic        busy;
   logic [1:0]  status;
   logic [15:0] result_outr, cycle_count;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   risc_host_loader #(
      .WIDTH(16), .IR_DEPTH(32), .DM_DEPTH(256),
      .RD_LAT(1), .MAX_CYCLES(20), .RST_HOLD(2)
   ) dut (
      .clk(clk), .cpu_reset_n(cpu_reset_n), .start(start),
      .ir_len(ir_len), .dm_len(dm_len), .dump_len(dump_len),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
      .ext_IR_we(ext_IR_we), .ext_DM_we(ext_DM_we), .ext_addr(ext_addr),
      .ext_data(ext_data), .test_normal(test_normal), .core_reset_n(core_reset_n),
      .mem_out(mem_out), .outR(outR), .done(done), .busy(busy),
      .status(status), .result_outr(result_outr), .cycle_count(cycle_count)
   );

   // Core data memory model with one cycle of read latency.
   logic [15:0] dm [0:255];
   always @(posedge clk) begin
      if (test_normal && ext_DM_we) dm[ext_addr] <= ext_data;
      mem_out <= dm[ext_addr];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [5:0] il, input logic [8:0] dl, input logic [8:0] ul);
      ir_len = il; dm_len = dl; dump_len = ul;
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_run(input string tag);
      int n = 0;
      while (core_reset_n !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk(tag, core_reset_n, 1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ctrl"}, {core_reset_n, test_normal, s_ready, m_valid, busy,
                           ext_IR_we, ext_DM_we, status}, {1'b0, 1'b1, 7'd0});
      chk({tag, "_ext"}, {ext_addr, ext_data}, 0);
      chk({tag, "_res"}, {result_outr, cycle_count}, 0);
      chk({tag, "_mdata"}, m_data, 0);
   endtask

   task automatic get_word(input string tag, input logic [15:0] exp, input int stall);
      int n = 0;
      while (m_valid !== 1'b1 && n < 10) begin
         tick();
         n++;
      end
      chk({tag, "_valid"}, m_valid, 1);
      chk(tag, m_data, exp);
      for (int i = 0; i < stall; i++) begin
         tick();
         chk({tag, "_stall"}, {m_valid, m_data}, {1'b1, exp});
      end
      m_ready = 1'b1;
      tick();
      m_ready = 1'b0;
      chk({tag, "_drop"}, m_valid, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      #12;
      chk_reset("reset");
      @(negedge clk);
      cpu_reset_n = 1'b1;
      tick();

      // Program load, back-to-back words, then done after 10 run cycles
      do_start(6'd3, 9'd0, 9'd0);
      chk("a_busy_rdy", {busy, s_ready, core_reset_n, test_normal}, 4'b1101);
      s_valid = 1'b1; s_data = 16'hA001;
      tick();
      chk("a_ir0", {ext_IR_we, ext_DM_we, ext_addr, ext_data}, {2'b10, 8'h00, 16'hA001});
      s_data = 16'hB002;
      tick();
      chk("a_ir1", {ext_IR_we, ext_DM_we, ext_addr, ext_data}, {2'b10, 8'h01, 16'hB002});
      s_data = 16'hC003;
      tick();
      chk("a_ir2", {ext_IR_we, ext_DM_we, ext_addr, ext_data}, {2'b10, 8'h02, 16'hC003});
      chk("a_sready_drop", s_ready, 0);
      s_valid = 1'b0; s_data = '0;
      tick();
      chk("a_we_end", ext_IR_we, 0);
      wait_run("a_run");
      chk("a_tn_run", test_normal, 0);
      repeat (10) @(posedge clk);
      #1;
      chk("a_cnt_pre", cycle_count, 10);
      done = 1'b1; outR = 16'h00AB;
      tick();
      chk("a_status", status, 2'b01);
      chk("a_result", result_outr, 16'h00AB);
      chk("a_cycles", cycle_count, 10);
      chk("a_core_held", {core_reset_n, test_normal, busy}, 3'b011);
      done = 1'b0; outR = '0;
      tick();
      chk("a_idle", {busy, status}, 3'b001);

      // DM preload with a gapped stream and a surplus word
      do_start(6'd0, 9'd2, 9'd0);
      chk("b_rdy", s_ready, 1);
      s_valid = 1'b1; s_data = 16'h1234;
      tick();
      chk("b_dm0", {ext_IR_we, ext_DM_we, ext_addr, ext_data}, {2'b01, 8'h00, 16'h1234});
      s_valid = 1'b0;
      tick();
      chk("b_gap", {ext_IR_we, ext_DM_we}, 2'b00);
      s_valid = 1'b1; s_data = 16'h5678;
      tick();
      chk("b_dm1", {ext_IR_we, ext_DM_we, ext_addr, ext_data}, {2'b01, 8'h01, 16'h5678});
      chk("b_sready_drop", s_ready, 0);
      s_data = 16'h9999;
      tick();
      chk("b_surplus", {ext_DM_we, s_ready}, 2'b00);
      s_valid = 1'b0;
      wait_run("b_run");
      done = 1'b1; outR = 16'h5555;
      tick();
      chk("b_done", {status, result_outr, cycle_count}, {2'b01, 16'h5555, 16'd0});
      done = 1'b0;
      tick();
      chk("b_idle", busy, 0);

      // Load 4 DM words, watchdog timeout, dump with backpressure
      do_start(6'd0, 9'd4, 9'd4);
      s_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         s_data = 16'((i + 1) * 17);
         tick();
         chk("c_dm", {ext_DM_we, ext_addr, ext_data}, {1'b1, 8'(i), 16'((i + 1) * 17)});
      end
      s_valid = 1'b0;
      wait_run("c_run");
      outR = 16'h0BAD;
      repeat (20) @(posedge clk);
      #1;
      chk("c_at_limit", {status, cycle_count}, {2'b00, 16'd20});
      tick();
      chk("c_timeout", {status, result_outr, cycle_count}, {2'b10, 16'h0BAD, 16'd20});
      chk("c_core_held", {core_reset_n, test_normal, ext_DM_we}, 3'b010);
      get_word("c_w0", 16'h0011, 0);
      get_word("c_w1", 16'h0022, 3);
      get_word("c_w2", 16'h0033, 0);
      get_word("c_w3", 16'h0044, 0);
      chk("c_busy_finish", busy, 1);
      tick();
      chk("c_idle", {busy, status}, 3'b010);

      // Abort mid-load, then a clean job that sees the partial write
      do_start(6'd0, 9'd3, 9'd0);
      s_valid = 1'b1; s_data = 16'h7777;
      tick();
      s_data = 16'h8888;
      tick();
      chk("d_pre", {ext_DM_we, ext_addr, busy}, {1'b1, 8'h01, 1'b1});
      #2;
      cpu_reset_n = 1'b0;
      #1;
      chk_reset("d_abort");
      s_valid = 1'b0;
      @(negedge clk);
      cpu_reset_n = 1'b1;
      tick();
      chk("d_idle", {busy, s_ready, ext_DM_we}, 3'b000);

      do_start(6'd1, 9'd0, 9'd2);
      s_valid = 1'b1; s_data = 16'h4242;
      tick();
      chk("e_ir0", {ext_IR_we, ext_DM_we, ext_addr, ext_data}, {2'b10, 8'h00, 16'h4242});
      s_valid = 1'b0;
      wait_run("e_run");
      done = 1'b1; outR = 16'h0001;
      tick();
      chk("e_done", {status, result_outr, cycle_count}, {2'b01, 16'h0001, 16'd0});
      done = 1'b0;
      get_word("e_w0", 16'h7777, 0);
      get_word("e_w1", 16'h0022, 0);
      tick();
      chk("e_idle", {busy, status, core_reset_n}, 4'b0010);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
